// File: rtl/mem_request_sequencer_pkg.sv
// Shared encodings for the memory-stage request path; writeback reuses the size decode.
package mem_request_sequencer_pkg;

    localparam logic [4:0] OP_WORD_LO = 5'd3;
    localparam logic [4:0] OP_WORD_HI = 5'd5;
    localparam logic [4:0] OP_HALF_LO = 5'd6;
    localparam logic [4:0] OP_HALF_HI = 5'd8;
    localparam logic [4:0] OP_BYTE_LO = 5'd9;
    localparam logic [4:0] OP_BYTE_HI = 5'd11;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        BEAT0 = ST_BEAT0,
        BEAT1 = ST_BEAT1
    } state_e;

    function automatic logic is_mem_opcode(input logic [4:0] opcode);
        return (opcode >= OP_WORD_LO) && (opcode <= OP_BYTE_HI);
    endfunction

    function automatic size_e decode_size(input logic [4:0] opcode);
        size_e sz;
        if (opcode <= OP_WORD_HI)
            sz = SZ_WORD;
        else if (opcode <= OP_HALF_HI)
            sz = SZ_HALF;
        else
            sz = SZ_BYTE;
        return sz;
    endfunction

    // An access is split when its bytes cross into the next word.
    function automatic logic needs_split(input size_e size, input logic [1:0] offset);
        logic sp;
        case (size)
            SZ_WORD: sp = (offset != 2'd0);
            SZ_HALF: sp = (offset == 2'd3);
            default: sp = 1'b0;
        endcase
        return sp;
    endfunction

endpackage

// File: rtl/mem_request_sequencer_store_lane_shift.sv
// Byte-enable and write-data lane placement for one beat of a (possibly split) store.
module store_lane_shift
    import mem_request_sequencer_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        beat,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata
);

    logic [4:0] lo_shift;
    logic [5:0] hi_shift;

    assign lo_shift = {offset, 3'b000};
    assign hi_shift = 6'd32 - {1'b0, lo_shift};

    // Beat 1 carries whatever spilled past lane 3 on beat 0.
    always_comb begin
        be    = 4'b0000;
        wdata = 32'h0000_0000;
        case (size)
            SZ_BYTE: begin
                if (!beat) begin
                    be    = 4'b0001 << offset;
                    wdata = {24'h0, store_data[7:0]} << lo_shift;
                end
            end
            SZ_HALF: begin
                if (!beat) begin
                    be    = 4'b0011 << offset;
                    wdata = {16'h0, store_data[15:0]} << lo_shift;
                end else begin
                    be    = 4'b0001;
                    wdata = {24'h0, store_data[15:8]};
                end
            end
            SZ_WORD: begin
                if (!beat) begin
                    be    = 4'b1111 << offset;
                    wdata = store_data << lo_shift;
                end else begin
                    be    = 4'b1111 >> (3'd4 - {1'b0, offset});
                    wdata = store_data >> hi_shift;
                end
            end
            default: begin
                be    = 4'b0000;
                wdata = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_request_sequencer.sv
// Turns one load/store into one or two word-aligned memory beats and stalls upstream meanwhile.
//   state | meaning
//   IDLE  | no beat presented
//   BEAT0 | first (or only) beat presented, held until mem_ready
//   BEAT1 | second beat of a split access presented, held until mem_ready
module mem_request_sequencer
    import mem_request_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        halt,
    input  logic        valid_in,
    input  logic [4:0]  opcode,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    output logic        done_out,
    output logic        done_misaligned
);

    state_e      state;
    state_e      state_nxt;
    size_e       size_q;
    size_e       size_in;
    size_e       ls_size;
    logic [1:0]  offset_q;
    logic [1:0]  ls_offset;
    logic [31:0] sdata_q;
    logic [31:0] ls_data;
    logic        split_q;
    logic        split_in;
    logic        ls_beat;
    logic [3:0]  ls_be;
    logic [31:0] ls_wdata;

    logic run;
    logic mem_op;
    logic last_beat;
    logic ready;
    logic accept;
    logic hs_last;
    logic to_beat1;

    assign run       = clk_en & ~halt;
    assign mem_op    = valid_in & (is_load | is_store) & is_mem_opcode(opcode);
    assign size_in   = decode_size(opcode);
    assign split_in  = needs_split(size_in, addr[1:0]);

    assign last_beat = (state == BEAT1) | ((state == BEAT0) & ~split_q);
    assign ready     = (state == IDLE) | (mem_ready & last_beat);
    assign accept    = mem_op & ready & run;
    assign stall_out = mem_op & ~ready;

    assign hs_last   = run & mem_ready & last_beat;
    assign to_beat1  = run & mem_ready & (state == BEAT0) & split_q;

    assign done_out        = hs_last;
    assign done_misaligned = hs_last & split_q;

    // While a split beat 0 is up no new op can be accepted, so the shifter is free to
    // compute beat 1 from the held op; otherwise it computes beat 0 of the incoming op.
    assign ls_beat   = (state == BEAT0) & split_q;
    assign ls_size   = ls_beat ? size_q   : size_in;
    assign ls_offset = ls_beat ? offset_q : addr[1:0];
    assign ls_data   = ls_beat ? sdata_q  : store_data;

    store_lane_shift u_store_lane_shift (
        .size       (ls_size),
        .offset     (ls_offset),
        .beat       (ls_beat),
        .store_data (ls_data),
        .be         (ls_be),
        .wdata      (ls_wdata)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = BEAT0;
            end
            BEAT0: begin
                if (mem_ready) begin
                    if (split_q)
                        state_nxt = BEAT1;
                    else if (accept)
                        state_nxt = BEAT0;
                    else
                        state_nxt = IDLE;
                end
            end
            BEAT1: begin
                if (mem_ready)
                    state_nxt = accept ? BEAT0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'h0;
            size_q    <= SZ_WORD;
            offset_q  <= 2'd0;
            sdata_q   <= 32'h0;
            split_q   <= 1'b0;
        end else if (run) begin
            state   <= state_nxt;
            mem_req <= (state_nxt != IDLE);
            if (accept) begin
                size_q    <= size_in;
                offset_q  <= addr[1:0];
                sdata_q   <= store_data;
                split_q   <= split_in;
                mem_we    <= is_store;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_be    <= is_store ? ls_be : 4'hF;
                mem_wdata <= is_store ? ls_wdata : 32'h0;
            end else if (to_beat1) begin
                mem_addr  <= mem_addr + 32'd4;
                mem_be    <= mem_we ? ls_be : 4'hF;
                mem_wdata <= mem_we ? ls_wdata : 32'h0;
            end else if (hs_last) begin
                mem_we    <= 1'b0;
                mem_addr  <= 32'h0;
                mem_wdata <= 32'h0;
                mem_be    <= 4'h0;
                split_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Self-checking bench: vector table, directed corner sequences, then random traffic vs a beat-queue model.
module tb_mem_request_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        halt = 1'b0;
    logic        valid_in = 1'b0;
    logic [4:0]  opcode = 5'd0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        mem_ready = 1'b0;
    logic        stall_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done_out;
    logic        done_misaligned;

    int n_cmp = 0;
    int n_bad = 0;

    mem_request_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_en          (clk_en),
        .halt            (halt),
        .valid_in        (valid_in),
        .opcode          (opcode),
        .is_load         (is_load),
        .is_store        (is_store),
        .addr            (addr),
        .store_data      (store_data),
        .stall_out       (stall_out),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .mem_ready       (mem_ready),
        .done_out        (done_out),
        .done_misaligned (done_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_beat(input string tag, input logic we, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] w);
        chk({tag, ".req"},   mem_req,   1);
        chk({tag, ".we"},    mem_we,    we);
        chk({tag, ".addr"},  mem_addr,  a);
        chk({tag, ".be"},    mem_be,    be);
        chk({tag, ".wdata"}, mem_wdata, w);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req"},   mem_req,         0);
        chk({tag, ".we"},    mem_we,          0);
        chk({tag, ".addr"},  mem_addr,        0);
        chk({tag, ".wdata"}, mem_wdata,       0);
        chk({tag, ".be"},    mem_be,          0);
        chk({tag, ".done"},  done_out,        0);
        chk({tag, ".mis"},   done_misaligned, 0);
        chk({tag, ".stall"}, stall_out,       0);
    endtask

    task automatic drive_op(input logic [4:0] opc, input logic ld, input logic st,
                            input logic [31:0] a, input logic [31:0] d);
        valid_in = 1'b1; opcode = opc; is_load = ld; is_store = st; addr = a; store_data = d;
    endtask

    task automatic drive_bubble();
        valid_in = 1'b0; opcode = 5'd0; is_load = 1'b0; is_store = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  opc;
        logic        ld;
        logic        st;
        logic [31:0] a;
        logic [31:0] d;
        logic        split;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] w0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] w1;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    // Reference model: queue of beats still to be presented for the op in flight.
    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] w;
        logic        split;
    } beat_t;

    beat_t q[$];

    task automatic push_op(input logic [4:0] opc, input logic st, input logic [31:0] a,
                           input logic [31:0] d);
        int          nbytes;
        logic [7:0]  bmask;
        logic [31:0] dmask;
        logic [63:0] wide;
        logic [31:0] base;
        logic        sp;
        beat_t       b;
        if (opc <= 5)      nbytes = 4;
        else if (opc <= 8) nbytes = 2;
        else               nbytes = 1;
        bmask = 8'((1 << nbytes) - 1);
        bmask = bmask << a[1:0];
        dmask = (nbytes == 4) ? 32'hFFFF_FFFF : (nbytes == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
        wide  = {32'h0, d & dmask} << (8 * int'(a[1:0]));
        sp    = |bmask[7:4];
        base  = {a[31:2], 2'b00};
        b.a = base; b.we = st; b.split = sp;
        b.be = st ? bmask[3:0] : 4'hF;
        b.w  = st ? wide[31:0] : 32'h0;
        q.push_back(b);
        if (sp) begin
            b.a  = base + 32'd4;
            b.be = st ? bmask[7:4] : 4'hF;
            b.w  = st ? wide[63:32] : 32'h0;
            q.push_back(b);
        end
    endtask

    logic memop_m, pres_m, ready_m, run_m, done_m;

    initial begin
        vecs[0]  = '{5'd10, 1'b0, 1'b1, 32'h0000_1003, 32'h0000_00AB, 1'b0, 32'h0000_1000, 4'b1000, 32'hAB00_0000, 32'h0, 4'h0, 32'h0};
        vecs[1]  = '{5'd4,  1'b0, 1'b1, 32'h0000_2001, 32'h1122_3344, 1'b1, 32'h0000_2000, 4'b1110, 32'h2233_4400, 32'h0000_2004, 4'b0001, 32'h0000_0011};
        vecs[2]  = '{5'd7,  1'b0, 1'b1, 32'h0000_3003, 32'h0000_BEEF, 1'b1, 32'h0000_3000, 4'b1000, 32'hEF00_0000, 32'h0000_3004, 4'b0001, 32'h0000_00BE};
        vecs[3]  = '{5'd3,  1'b1, 1'b0, 32'hFFFF_FFFE, 32'h1234_5678, 1'b1, 32'hFFFF_FFFC, 4'b1111, 32'h0,         32'h0000_0000, 4'b1111, 32'h0};
        vecs[4]  = '{5'd8,  1'b0, 1'b1, 32'h0000_4002, 32'h1234_ABCD, 1'b0, 32'h0000_4000, 4'b1100, 32'hABCD_0000, 32'h0, 4'h0, 32'h0};
        vecs[5]  = '{5'd5,  1'b0, 1'b1, 32'h0000_5000, 32'hDEAD_BEEF, 1'b0, 32'h0000_5000, 4'b1111, 32'hDEAD_BEEF, 32'h0, 4'h0, 32'h0};
        vecs[6]  = '{5'd11, 1'b0, 1'b1, 32'h0000_6001, 32'hFFFF_FFC3, 1'b0, 32'h0000_6000, 4'b0010, 32'h0000_C300, 32'h0, 4'h0, 32'h0};
        vecs[7]  = '{5'd4,  1'b0, 1'b1, 32'h0000_7003, 32'hAABB_CCDD, 1'b1, 32'h0000_7000, 4'b1000, 32'hDD00_0000, 32'h0000_7004, 4'b0111, 32'h00AA_BBCC};
        vecs[8]  = '{5'd6,  1'b1, 1'b0, 32'h0000_8003, 32'h0,         1'b1, 32'h0000_8000, 4'b1111, 32'h0,         32'h0000_8004, 4'b1111, 32'h0};
        vecs[9]  = '{5'd9,  1'b0, 1'b1, 32'h0000_1002, 32'h0000_55AA, 1'b0, 32'h0000_1000, 4'b0100, 32'h00AA_0000, 32'h0, 4'h0, 32'h0};
        vecs[10] = '{5'd4,  1'b0, 1'b1, 32'h0000_2002, 32'h1122_3344, 1'b1, 32'h0000_2000, 4'b1100, 32'h3344_0000, 32'h0000_2004, 4'b0011, 32'h0000_1122};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single ops with immediate mem_ready
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive_op(vecs[i].opc, vecs[i].ld, vecs[i].st, vecs[i].a, vecs[i].d);
            mem_ready = 1'b1;
            #1 chk($sformatf("vec%0d.idle_stall", i), stall_out, 0);
            @(negedge clk);
            drive_bubble();
            #1;
            chk_beat($sformatf("vec%0d.b0", i), vecs[i].st, vecs[i].a0, vecs[i].be0, vecs[i].w0);
            chk($sformatf("vec%0d.b0.done", i), done_out, !vecs[i].split);
            chk($sformatf("vec%0d.b0.mis", i), done_misaligned, 0);
            if (vecs[i].split) begin
                @(negedge clk);
                #1;
                chk_beat($sformatf("vec%0d.b1", i), vecs[i].st, vecs[i].a1, vecs[i].be1, vecs[i].w1);
                chk($sformatf("vec%0d.b1.done", i), done_out, 1);
                chk($sformatf("vec%0d.b1.mis", i), done_misaligned, 1);
            end
            @(negedge clk);
            #1 chk($sformatf("vec%0d.idle_req", i), mem_req, 0);
        end

        // Split store stalls the following memory op for one cycle
        @(negedge clk);
        drive_op(5'd4, 1'b0, 1'b1, 32'h0000_2001, 32'h1122_3344);
        mem_ready = 1'b1;
        @(negedge clk);
        drive_op(5'd9, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_005A);
        #1;
        chk("split.n1.stall", stall_out, 1);
        chk_beat("split.n1", 1'b1, 32'h0000_2000, 4'b1110, 32'h2233_4400);
        @(negedge clk);
        #1;
        chk("split.n2.stall", stall_out, 0);
        chk_beat("split.n2", 1'b1, 32'h0000_2004, 4'b0001, 32'h0000_0011);
        chk("split.n2.mis", done_misaligned, 1);
        @(negedge clk);
        drive_bubble();
        #1;
        chk_beat("split.next", 1'b1, 32'h0000_0020, 4'b0001, 32'h0000_005A);
        chk("split.next.done", done_out, 1);
        chk("split.next.mis", done_misaligned, 0);
        @(negedge clk);
        #1 chk("split.idle", mem_req, 0);

        // mem_ready held low for three cycles
        @(negedge clk);
        drive_op(5'd5, 1'b0, 1'b1, 32'h0000_9000, 32'hCAFE_F00D);
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_op(5'd6, 1'b0, 1'b1, 32'h0000_9102, 32'h0000_7777);
            mem_ready = 1'b0;
            #1;
            chk_beat($sformatf("wait%0d", k), 1'b1, 32'h0000_9000, 4'b1111, 32'hCAFE_F00D);
            chk($sformatf("wait%0d.stall", k), stall_out, 1);
            chk($sformatf("wait%0d.done", k), done_out, 0);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk_beat("wait.hs", 1'b1, 32'h0000_9000, 4'b1111, 32'hCAFE_F00D);
        chk("wait.hs.stall", stall_out, 0);
        chk("wait.hs.done", done_out, 1);
        @(negedge clk);
        drive_bubble();
        #1;
        chk_beat("wait.next", 1'b1, 32'h0000_9100, 4'b1100, 32'h7777_0000);
        chk("wait.next.done", done_out, 1);
        @(negedge clk);
        #1 chk("wait.idle", mem_req, 0);

        // Reset in the middle of a split store
        @(negedge clk);
        drive_op(5'd4, 1'b0, 1'b1, 32'h0000_2001, 32'h1122_3344);
        mem_ready = 1'b1;
        @(negedge clk);
        drive_bubble();
        #1 chk("rst.b0.addr", mem_addr, 32'h0000_2000);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1 chk("rst.b1.addr", mem_addr, 32'h0000_2004);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1 chk_all_zero("rst.after");
        @(negedge clk);
        #1 chk("rst.no_b1", mem_req, 0);

        // Non-memory ops: never accepted, never stall
        @(negedge clk);
        drive_op(5'd12, 1'b0, 1'b1, 32'h0000_0100, 32'h1);
        #1 chk("nonmem.stall", stall_out, 0);
        @(negedge clk);
        drive_op(5'd3, 1'b0, 1'b0, 32'h0000_0100, 32'h1);
        #1 chk("nonmem.req0", mem_req, 0);
        @(negedge clk);
        drive_bubble();
        #1 chk("nonmem.req1", mem_req, 0);

        // Freeze through clk_en and halt with mem_ready high
        @(negedge clk);
        drive_op(5'd3, 1'b0, 1'b1, 32'h0000_A004, 32'h0000_0001);
        mem_ready = 1'b1;
        @(negedge clk);
        drive_bubble();
        clk_en = 1'b0;
        #1;
        chk("frz.en.done", done_out, 0);
        chk_beat("frz.en", 1'b1, 32'h0000_A004, 4'b1111, 32'h0000_0001);
        @(negedge clk);
        clk_en = 1'b1;
        halt = 1'b1;
        #1;
        chk("frz.halt.done", done_out, 0);
        chk_beat("frz.halt", 1'b1, 32'h0000_A004, 4'b1111, 32'h0000_0001);
        @(negedge clk);
        halt = 1'b0;
        #1 chk("frz.rel.done", done_out, 1);
        @(negedge clk);
        #1 chk("frz.idle", mem_req, 0);

        // Random traffic against the beat-queue model
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n      = ($urandom_range(0, 63) != 0);
            clk_en     = ($urandom_range(0, 7) != 0);
            halt       = ($urandom_range(0, 7) == 0);
            mem_ready  = ($urandom_range(0, 9) < 7);
            valid_in   = ($urandom_range(0, 9) < 7);
            opcode     = 5'($urandom_range(0, 13));
            {is_load, is_store} = 2'($urandom_range(0, 3));
            addr       = $urandom;
            if ($urandom_range(0, 3) == 0)
                addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            store_data = $urandom;
            #1;
            memop_m = valid_in && (is_load || is_store) && (opcode >= 5'd3) && (opcode <= 5'd11);
            pres_m  = (q.size() != 0);
            ready_m = !pres_m || (mem_ready && q.size() == 1);
            run_m   = clk_en && !halt;
            done_m  = run_m && pres_m && mem_ready && (q.size() == 1);
            chk("rnd.req", mem_req, pres_m);
            chk("rnd.stall", stall_out, memop_m && !ready_m);
            chk("rnd.done", done_out, done_m);
            if (pres_m) begin
                chk("rnd.mis", done_misaligned, done_m && q[0].split);
                chk("rnd.we", mem_we, q[0].we);
                chk("rnd.addr", mem_addr, q[0].a);
                chk("rnd.be", mem_be, q[0].be);
                chk("rnd.wdata", mem_wdata, q[0].w);
            end else begin
                chk("rnd.mis_idle", done_misaligned, 0);
            end
            @(posedge clk);
            if (!rst_n) begin
                q.delete();
            end else if (run_m) begin
                if (pres_m && mem_ready)
                    void'(q.pop_front());
                if (memop_m && ready_m)
                    push_op(opcode, is_store, addr, store_data);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_request_sequencer.md
# mem_request_sequencer

Memory-stage request generator feeding the data-memory port; the transmit side of the split-access protocol whose receive side merges returned words in writeback. Converts one load/store (opcode, byte address, store data) into one or two word-aligned memory beats with byte enables and lane-shifted write data. Stalls the pipeline while a misaligned access's second beat is outstanding. Tells writeback that a load was split, so the two returned words can be merged.

## Interface
- No parameters; data and address width fixed at 32, lane count fixed at 4.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- clk_en  in  1  global clock enable; when 0 all state holds.
- halt  in  1  when 1 all state holds, same as clk_en=0.
- valid_in  in  1  the op on the inputs is a real instruction, not a bubble.
- opcode  in  5  3–5 word, 6–8 half, 9–11 byte; anything else is a non-memory op.
- is_load  in  1  op reads memory.
- is_store  in  1  op writes memory.
- addr  in  32  effective byte address.
- store_data  in  32  value to store, right-justified.
- stall_out  out  1  holds the upstream stages.
- mem_req  out  1  a beat is presented to memory.
- mem_we  out  1  the presented beat is a write.
- mem_addr  out  32  word-aligned address (bits 1:0 always 0).
- mem_wdata  out  32  lane-positioned write data.
- mem_be  out  4  byte enables; lane k is bits 8k+7:8k.
- mem_ready  in  1  memory accepts the presented beat this cycle.
- done_out  out  1  one-cycle pulse when the op's last beat is accepted.
- done_misaligned  out  1  qualifies done_out; 1 means the op was split (feeds writeback's misaligned flag).

## Operation
- Accept = valid_in & (is_load | is_store) & opcode in 3..11 & ready & clk_en & ~halt.
  - ready = (state == IDLE) | (mem_ready & last beat presented).
- Non-memory ops and bubbles are never accepted and never stall.
- Split rule, with o = addr[1:0]:
  - word with o≠0 is split; half with o=3 is split; byte is never split.
- Beat 0 address is addr & ~3; beat 1 address is beat 0 address + 4 (wraps modulo 2^32).
- Beat 0 enables and data:
  - byte: be = 1<<o; wdata = (store_data & FF) << 8o.
  - half, o=0..2: be = 3<<o; wdata = (store_data & FFFF) << 8o.
  - half, o=3: be = 1000; wdata = store_data << 24.
  - word: be = (1111<<o) & 1111; wdata = store_data << 8o.
- Beat 1 enables and data:
  - half: be = 0001; wdata = (store_data >> 8) & FF.
  - word: be = 1111 >> (4−o); wdata = store_data >> (32−8o).
- Loads drive mem_we=0, be=1111 and wdata=0 on every beat.
- States:
  - IDLE: mem_req=0. On accept go to BEAT0.
  - BEAT0: mem_req=1, outputs held until mem_ready.
    - On mem_ready: if split go to BEAT1.
    - Otherwise go to BEAT0 with the new op if one is accepted in the same cycle (back-to-back), else IDLE.
  - BEAT1: mem_req=1, outputs held.
    - On mem_ready: go to BEAT0 with the new op if one is accepted, else IDLE.
- stall_out = valid_in & (is_load | is_store) & opcode in 3..11 & ~ready.
- Freeze: while clk_en=0 or halt=1, state and every registered output hold; mem_req stays up and mem_ready is ignored.

## Timing
- Op accepted in cycle N: beat 0 appears on mem_* in cycle N+1. All request outputs are registered.
- Unsplit op with immediate mem_ready: 1 beat, no stall; done_out asserts in cycle N+1.
- Split op with immediate mem_ready: beat 1 in N+2, done_out in N+2. stall_out is high during N+1 for the following memory op.
- mem_ready held low: the beat and all mem_* outputs hold unchanged; stall_out stays high for any waiting memory op.
- done_out and done_misaligned are combinational from the last-beat handshake and gated by clk_en & ~halt.
- Reset (rst_n=0 at an edge), including mid-split:
  - state → IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, mem_be, done_out, done_misaligned, stall_out all read 0 the next cycle.
  - A pending beat 1 is dropped.

## Structure
- Shared package holds:
  - opcode range constants: word 3–5, half 6–8, byte 9–11;
  - size enum {SZ_WORD, SZ_HALF, SZ_BYTE};
  - state enum {IDLE, BEAT0, BEAT1}.
- Writeback uses the same package for its size decode.
- One sub-module, store_lane_shift (combinational):
  - inputs size, offset, beat, store_data;
  - outputs be and wdata.

## Test plan
- Store byte, addr=0x1003, data=0xAB, ready=1 → one beat: addr 0x1000, be 1000, wdata 0xAB000000, done with done_misaligned=0.
- Store word, addr=0x2001, data=0x11223344 → beat 0: 0x2000, be 1110, wdata 0x22334400; beat 1: 0x2004, be 0001, wdata 0x11. Upstream memory op stalled 1 cycle; done_misaligned=1.
- Store half, addr=0x3003, data=0xBEEF → beat 0: 0x3000, be 1000, wdata 0xEF000000; beat 1: 0x3004, be 0001, wdata 0xBE.
- Load word, addr=0xFFFFFFFE → beats at 0xFFFFFFFC then 0x00000000 (wrap), be 1111, mem_we=0, done_misaligned=1.
- Aligned store with mem_ready low for 3 cycles, then high → outputs stable for 4 cycles, stall_out high throughout for a following store, which issues the cycle after the handshake.
- Reset asserted during BEAT1 of a split word store → next cycle all outputs 0, state IDLE, no beat 1 issued.
